// File: rtl/fmap_bank_scheduler.sv
// Frame controller for the feature-map bank: loads an image from the UART,
// runs the conv core, then streams the result region and label back out.
module fmap_bank_scheduler #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int IMG_BYTES = 784,
    parameter int RES_BASE  = 0,
    parameter int RES_BYTES = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              core_init,
    input  logic              core_done,
    input  logic [3:0]        core_label,
    input  logic [ADDR_W-1:0] c_waddr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              c_wen,
    input  logic [ADDR_W-1:0] c_raddr,
    input  logic              c_ren,
    output logic [DATA_W-1:0] c_rdata,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              fb_wen,
    output logic [ADDR_W-1:0] fb_raddr,
    output logic              fb_ren,
    input  logic [DATA_W-1:0] fb_rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    input  logic              tx_ready,
    output logic [3:0]        label,
    output logic              frame_done,
    output logic              ovf
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_START    = 4'd2;
    localparam logic [3:0] S_RUN      = 4'd3;
    localparam logic [3:0] S_RD_ISSUE = 4'd4;
    localparam logic [3:0] S_RD_LATCH = 4'd5;
    localparam logic [3:0] S_SEND     = 4'd6;
    localparam logic [3:0] S_SEND_LBL = 4'd7;
    localparam logic [3:0] S_FIN      = 4'd8;

    localparam logic [15:0]       IMG_LAST   = 16'(IMG_BYTES - 1);
    localparam logic [15:0]       RES_CNT    = 16'(RES_BYTES);
    localparam logic [ADDR_W-1:0] RES_BASE_A = ADDR_W'(RES_BASE);

    logic [3:0]        state_reg, state_next;
    logic [15:0]       cnt_reg;
    logic [15:0]       idx_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [DATA_W-1:0] tx_data_reg;
    logic [3:0]        label_reg;
    logic              ovf_reg;

    logic is_idle, is_load, is_run, core_sel, ld_accept;

    assign is_idle   = (state_reg == S_IDLE);
    assign is_load   = (state_reg == S_LOAD);
    assign is_run    = (state_reg == S_RUN);
    assign core_sel  = (state_reg == S_START) || is_run;
    assign ld_accept = ld_valid && (is_idle || is_load);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (ld_valid) state_next = (IMG_BYTES == 1) ? S_START : S_LOAD;
            S_LOAD:     if (ld_valid && cnt_reg == IMG_LAST) state_next = S_START;
            S_START:    state_next = S_RUN;
            S_RUN:      if (core_done) state_next = (RES_BYTES == 0) ? S_SEND_LBL : S_RD_ISSUE;
            S_RD_ISSUE: state_next = S_RD_LATCH;
            S_RD_LATCH: state_next = S_SEND;
            S_SEND:     if (tx_ready) state_next = (idx_reg + 16'd1 == RES_CNT) ? S_SEND_LBL : S_RD_ISSUE;
            S_SEND_LBL: if (tx_ready) state_next = S_FIN;
            S_FIN:      state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            tx_data_reg <= '0;
            label_reg   <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= ld_accept;
            // The first byte of a frame always lands at address 0, whatever cnt holds.
            if (ld_accept) begin
                wr_addr_reg <= is_idle ? '0 : ADDR_W'(cnt_reg);
                wr_data_reg <= ld_data;
                cnt_reg     <= is_idle ? 16'd1 : cnt_reg + 16'd1;
            end
            if (ld_valid && !(is_idle || is_load)) begin
                ovf_reg <= 1'b1;
            end
            if (is_idle && ld_valid) begin
                label_reg <= '0;
            end else if (is_run && core_done) begin
                label_reg <= core_label;
            end
            if (is_run && core_done) begin
                idx_reg <= '0;
            end else if (state_reg == S_SEND && tx_ready) begin
                idx_reg <= idx_reg + 16'd1;
            end
            if (state_reg == S_RD_LATCH) begin
                tx_data_reg <= fb_rdata;
            end
        end
    end

    // Port A: the pending loader write owns the port (it is still in flight
    // during START); core writes only pass through while running.
    always_comb begin
        fb_wen   = wr_en_reg || (is_run && c_wen);
        fb_waddr = '0;
        fb_wdata = '0;
        if (wr_en_reg) begin
            fb_waddr = wr_addr_reg;
            fb_wdata = wr_data_reg;
        end else if (is_run) begin
            fb_waddr = c_waddr;
            fb_wdata = c_wdata;
        end
    end

    always_comb begin
        fb_ren   = 1'b0;
        fb_raddr = '0;
        if (state_reg == S_RD_ISSUE) begin
            fb_ren   = 1'b1;
            fb_raddr = RES_BASE_A + ADDR_W'(idx_reg);
        end else if (core_sel) begin
            fb_ren   = c_ren;
            fb_raddr = c_raddr;
        end
    end

    always_comb begin
        tx_req  = (state_reg == S_SEND) || (state_reg == S_SEND_LBL);
        tx_data = '0;
        if (state_reg == S_SEND) begin
            tx_data = tx_data_reg;
        end else if (state_reg == S_SEND_LBL) begin
            tx_data = {{(DATA_W-4){1'b0}}, label_reg};
        end
    end

    assign c_rdata    = fb_rdata;
    assign core_init  = (state_reg == S_START);
    assign frame_done = (state_reg == S_FIN);
    assign label      = label_reg;
    assign ovf        = ovf_reg;

endmodule

// File: tb/tb_fmap_bank_scheduler.sv
// Randomized frame-level bench for fmap_bank_scheduler against a bank/queue model.
module tb_fmap_bank_scheduler;

    localparam int AW  = 15;
    localparam int IMG = 784;
    localparam int RB  = 0;
    localparam int RN  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        core_init;
    logic        core_done;
    logic [3:0]  core_label;
    logic [14:0] c_waddr;
    logic [7:0]  c_wdata;
    logic        c_wen;
    logic [14:0] c_raddr;
    logic        c_ren;
    logic [7:0]  c_rdata;
    logic [14:0] fb_waddr;
    logic [7:0]  fb_wdata;
    logic        fb_wen;
    logic [14:0] fb_raddr;
    logic        fb_ren;
    logic [7:0]  fb_rdata;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_ready;
    logic [3:0]  label;
    logic        frame_done;
    logic        ovf;

    fmap_bank_scheduler dut (
        .clk(clk), .rstn(rstn), .ld_data(ld_data), .ld_valid(ld_valid),
        .core_init(core_init), .core_done(core_done), .core_label(core_label),
        .c_waddr(c_waddr), .c_wdata(c_wdata), .c_wen(c_wen),
        .c_raddr(c_raddr), .c_ren(c_ren), .c_rdata(c_rdata),
        .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_wen(fb_wen),
        .fb_raddr(fb_raddr), .fb_ren(fb_ren), .fb_rdata(fb_rdata),
        .tx_data(tx_data), .tx_req(tx_req), .tx_ready(tx_ready),
        .label(label), .frame_done(frame_done), .ovf(ovf)
    );

    // Second build: tiny image and no result bytes, so only the label is sent.
    logic [7:0]  ld_data_z;
    logic        ld_valid_z, core_done_z, tx_ready_z;
    logic [3:0]  core_label_z;
    logic [14:0] zero_a;
    logic [7:0]  zero_d;
    logic        zero_b;
    logic        core_init_z, fb_wen_z, fb_ren_z, tx_req_z, frame_done_z, ovf_z;
    logic [7:0]  c_rdata_z, fb_wdata_z, tx_data_z;
    logic [14:0] fb_waddr_z, fb_raddr_z;
    logic [3:0]  label_z;

    fmap_bank_scheduler #(.IMG_BYTES(4), .RES_BYTES(0)) dut_z (
        .clk(clk), .rstn(rstn), .ld_data(ld_data_z), .ld_valid(ld_valid_z),
        .core_init(core_init_z), .core_done(core_done_z), .core_label(core_label_z),
        .c_waddr(zero_a), .c_wdata(zero_d), .c_wen(zero_b),
        .c_raddr(zero_a), .c_ren(zero_b), .c_rdata(c_rdata_z),
        .fb_waddr(fb_waddr_z), .fb_wdata(fb_wdata_z), .fb_wen(fb_wen_z),
        .fb_raddr(fb_raddr_z), .fb_ren(fb_ren_z), .fb_rdata(zero_d),
        .tx_data(tx_data_z), .tx_req(tx_req_z), .tx_ready(tx_ready_z),
        .label(label_z), .frame_done(frame_done_z), .ovf(ovf_z)
    );

    // Bank model: write port A, 1-cycle-latency read port B.
    logic [7:0] bank [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (fb_wen) bank[fb_waddr] <= fb_wdata;
        if (fb_ren) fb_rdata <= bank[fb_raddr];
    end

    logic [7:0] ref_mem [0:(1<<AW)-1];
    int exp_wr[$], obs_wr[$], exp_rd[$], obs_rd[$], exp_tx[$], obs_tx[$];
    int n_chk = 0, n_err = 0;
    int n_init, n_done, init_wr;
    bit hold_pend = 0, rd_pend = 0, rd_arm = 0, ovf_exp = 0;
    logic [7:0] hold_data, rd_exp, rd_exp_next;
    int ntx_z, nren_z, ninit_z, ndone_z, nwr_z;
    logic [7:0] tx_last_z;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_q(input string tag, input int obs[$], input int exp[$]);
        check({tag, "_len"}, obs.size(), exp.size());
        for (int i = 0; i < obs.size() && i < exp.size(); i++)
            if (obs[i] != exp[i]) check({tag, "_item"}, obs[i], exp[i]);
        $display("%s: %0d items compared", tag, exp.size());
    endtask

    // One clock cycle: sample outputs 1 time unit after the negedge drive, then
    // advance to the next negedge (the active edge falls in between).
    task automatic cyc();
        #1;
        if (fb_wen) obs_wr.push_back(int'(fb_waddr) * 256 + int'(fb_wdata));
        if (fb_ren) obs_rd.push_back(int'(fb_raddr));
        if (tx_req && tx_ready) begin
            obs_tx.push_back(int'(tx_data));
            $display("tx byte %0d: %02h", obs_tx.size() - 1, tx_data);
        end
        if (core_init) begin
            n_init++;
            init_wr = fb_wen ? int'(fb_waddr) : -1;
        end
        if (frame_done) n_done++;
        if (hold_pend) begin
            check("tx_hold_req", tx_req, 1);
            check("tx_hold_data", tx_data, hold_data);
        end
        hold_pend = tx_req && !tx_ready;
        hold_data = tx_data;
        if (rd_pend) check("c_rdata", c_rdata, rd_exp);
        rd_pend = rd_arm;
        rd_exp  = rd_exp_next;
        rd_arm  = 0;
        @(negedge clk);
    endtask

    task automatic cyc_z();
        #1;
        if (tx_req_z && tx_ready_z) begin ntx_z++; tx_last_z = tx_data_z; end
        if (fb_ren_z) nren_z++;
        if (fb_wen_z) nwr_z++;
        if (core_init_z) ninit_z++;
        if (frame_done_z) ndone_z++;
        @(negedge clk);
    endtask

    task automatic clear_core();
        c_wen = 0; c_waddr = '0; c_wdata = '0; c_ren = 0; c_raddr = '0;
        core_done = 0; core_label = '0;
    endtask

    task automatic junk_core();
        c_wen = 1'($urandom); c_waddr = 15'($urandom_range(0, IMG + 20)); c_wdata = 8'($urandom);
        c_ren = 1'($urandom); c_raddr = 15'($urandom_range(0, IMG - 1));
        core_done = 1'($urandom); core_label = 4'($urandom);
    endtask

    task automatic run_frame(input int pat, input bit gaps, input bit stall,
                             input bit ovf_poke, input int abort_at);
        int lbl, ncyc, t, wait_cnt, a;
        lbl = (pat == 0) ? 7 : int'($urandom_range(0, 15));
        exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
        exp_tx.delete(); obs_tx.delete();
        ld_valid = 0; tx_ready = 0;
        for (int k = 0; k < 3; k++) begin junk_core(); cyc(); end
        n_init = 0; n_done = 0; init_wr = -2;
        exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
        // Load phase, core requests randomly asserted and expected to be gated.
        for (int k = 0; k < IMG; k++) begin
            if (gaps) while ($urandom_range(0, 3) == 0) begin ld_valid = 0; junk_core(); cyc(); end
            ld_valid = 1;
            ld_data  = (pat == 0) ? k[7:0] : 8'($urandom);
            junk_core();
            exp_wr.push_back(k * 256 + int'(ld_data));
            ref_mem[k] = ld_data;
            cyc();
            if (k == 0) check("label_clr", label, 0);
            if (k == abort_at) begin
                rstn = 0; ld_valid = 0; clear_core();
                cyc();
                rstn = 1;
                #1;
                check("rst_fb_wen", fb_wen, 0);
                check("rst_fb_ren", fb_ren, 0);
                check("rst_core_init", core_init, 0);
                check("rst_tx_req", tx_req, 0);
                check("rst_ovf", ovf, 0);
                check("rst_label", label, 0);
                @(negedge clk);
                ovf_exp = 0; hold_pend = 0; rd_pend = 0;
                $display("frame aborted by reset after byte %0d", k);
                return;
            end
        end
        // START cycle: core_done must be ignored here.
        ld_valid = 0; clear_core(); core_done = 1'($urandom); core_label = 4'($urandom);
        cyc();
        check("init_in_start", n_init, 1);
        check("last_wr_with_init", init_wr, IMG - 1);
        ncyc = $urandom_range(2, 8);
        for (int j = 0; j < ncyc; j++) begin
            clear_core();
            ld_valid = ovf_poke && (j == 1);
            if (pat == 0 && j == 0) begin
                c_wen = 1; c_waddr = 15'h0010; c_wdata = 8'hA5;
            end else if (pat == 0 && j == 1) begin
                c_ren = 1; c_raddr = 15'h0010;
            end else begin
                c_wen = 1'($urandom); c_waddr = 15'($urandom_range(0, IMG + 20)); c_wdata = 8'($urandom);
                c_ren = 1'($urandom); c_raddr = 15'($urandom_range(0, IMG - 1));
            end
            if (c_ren) begin
                exp_rd.push_back(int'(c_raddr));
                rd_exp_next = ref_mem[c_raddr];
                rd_arm = 1;
            end
            if (c_wen) begin
                exp_wr.push_back(int'(c_waddr) * 256 + int'(c_wdata));
                ref_mem[c_waddr] = c_wdata;
            end
            cyc();
        end
        if (ovf_poke) ovf_exp = 1;
        ld_valid = 0; clear_core(); core_done = 1; core_label = 4'(lbl);
        cyc();
        for (int j = 0; j < RN; j++) begin
            a = (RB + j) % (1 << AW);
            exp_rd.push_back(a);
            exp_tx.push_back(int'(ref_mem[a]));
        end
        exp_tx.push_back(lbl);
        t = 0; wait_cnt = 0;
        while (n_done == 0 && t < 3000) begin
            junk_core(); ld_valid = 0;
            if (stall) tx_ready = tx_req && (wait_cnt >= 5);
            else       tx_ready = 1'($urandom);
            if (tx_req && !tx_ready) wait_cnt++; else wait_cnt = 0;
            cyc();
            t++;
        end
        check("readout_timeout", t < 3000, 1);
        tx_ready = 0; clear_core();
        cyc(); cyc();
        check("frame_done_cnt", n_done, 1);
        check("init_cnt", n_init, 1);
        check("label", label, lbl);
        check("ovf", ovf, ovf_exp);
        compare_q("port_a_writes", obs_wr, exp_wr);
        compare_q("port_b_reads", obs_rd, exp_rd);
        compare_q("tx_bytes", obs_tx, exp_tx);
        $display("frame pat=%0d label=%0d tx=%0d ovf=%0b", pat, lbl, obs_tx.size(), ovf);
    endtask

    initial begin
        rstn = 0; ld_valid = 0; ld_data = '0; tx_ready = 0; clear_core();
        ld_valid_z = 0; ld_data_z = '0; core_done_z = 0; core_label_z = '0; tx_ready_z = 0;
        zero_a = '0; zero_d = '0; zero_b = 0;
        @(negedge clk);
        cyc(); cyc(); cyc();
        #1;
        check("reset_fb_wen", fb_wen, 0);
        check("reset_fb_ren", fb_ren, 0);
        check("reset_fb_waddr", fb_waddr, 0);
        check("reset_tx_req", tx_req, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_core_init", core_init, 0);
        check("reset_label", label, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_ovf", ovf, 0);
        @(negedge clk);
        rstn = 1;
        cyc();

        run_frame(0, 0, 1, 0, -1);
        run_frame(1, 1, 0, 1, -1);
        run_frame(1, 1, 0, 0, -1);
        run_frame(0, 0, 0, 0, 300);
        run_frame(1, 0, 0, 0, -1);

        ntx_z = 0; nren_z = 0; ninit_z = 0; ndone_z = 0; nwr_z = 0; tx_last_z = '0;
        for (int k = 0; k < 4; k++) begin
            ld_valid_z = 1; ld_data_z = 8'($urandom);
            cyc_z();
        end
        ld_valid_z = 0;
        cyc_z();
        check("z_init", ninit_z, 1);
        core_done_z = 1; core_label_z = 4'hC;
        cyc_z();
        core_done_z = 0; tx_ready_z = 1;
        for (int t = 0; t < 20 && ndone_z == 0; t++) cyc_z();
        tx_ready_z = 0;
        cyc_z();
        check("z_writes", nwr_z, 4);
        check("z_tx_count", ntx_z, 1);
        check("z_tx_label", tx_last_z, 8'h0C);
        check("z_no_reads", nren_z, 0);
        check("z_done", ndone_z, 1);
        check("z_label", label_z, 4'hC);
        $display("label-only build: tx=%0d data=%02h", ntx_z, tx_last_z);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fmap_bank_scheduler.md
# fmap_bank_scheduler

Frame-level controller that owns both ports of the 32 KiB feature-map bank and schedules the bank between three users. The UART loader writes the input image, the conv core computes, and a readout engine streams the result region plus the label to the UART transmitter. It replaces the single-bit write-port select mux. It adds the load counting, the core start pulse, a port-B arbiter and the result readback, so one frame is handled end to end without host intervention.

## Interface
- ADDR_W, 15, bank address width
- DATA_W, 8, bank data width
- IMG_BYTES, 784, bytes loaded per frame, written to addresses 0..IMG_BYTES-1
- RES_BASE, 0, first address of the result region read back after compute
- RES_BYTES, 10, number of result bytes streamed out (0 allowed)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- ld_data  in  DATA_W  received UART byte
- ld_valid  in  1  one-cycle strobe per received byte
- core_init  out  1  one-cycle start pulse to core
- core_done  in  1  core completion (level or pulse)
- core_label  in  4  core classification result, valid with core_done
- c_waddr / c_wdata / c_wen  in  ADDR_W / DATA_W / 1  core write request
- c_raddr / c_ren  in  ADDR_W / 1  core read request
- c_rdata  out  DATA_W  bank port-B data to core (direct wire from fb_rdata)
- fb_waddr / fb_wdata / fb_wen  out  ADDR_W / DATA_W / 1  bank port A
- fb_raddr / fb_ren  out  ADDR_W / 1  bank port B
- fb_rdata  in  DATA_W  bank port-B data, 1-cycle read latency
- tx_data  out  DATA_W  byte to UART transmitter
- tx_req  out  1  byte valid; held with tx_data stable until accepted
- tx_ready  in  1  transfer occurs on a cycle with tx_req & tx_ready
- label  out  4  latched label of the last frame
- frame_done  out  1  one-cycle pulse at end of readout
- ovf  out  1  sticky: byte received outside IDLE/LOAD

## Operation
- States: IDLE, LOAD, START, RUN, RD_ISSUE, RD_LATCH, SEND, SEND_LBL, FIN.
- IDLE: the first ld_valid writes byte 0, clears label, and moves to LOAD.
- LOAD: each ld_valid writes at the address counter, then the counter increments.
- Loader writes are registered: fb_waddr, fb_wdata and fb_wen are driven in the cycle after ld_valid.
- The edge that captures byte IMG_BYTES-1 moves LOAD to START.
- START: lasts exactly one cycle, with core_init=1. Bank ports are muxed to the core from this cycle on.
- RUN: port A = {c_waddr, c_wdata, c_wen} and port B = {c_raddr, c_ren}, both combinational passthrough.
- RUN exits when core_done=1. The exit latches core_label into label, clears the byte index i, and goes to RD_ISSUE, or to SEND_LBL if RES_BYTES=0.
- Outside START and RUN, core requests are gated: fb_wen and fb_ren are never driven from c_wen or c_ren.
- RD_ISSUE: fb_ren=1 and fb_raddr=RES_BASE+i for one cycle, then RD_LATCH.
- RD_LATCH: tx_data is captured from fb_rdata, then SEND.
- SEND: tx_req=1 until the transfer. The transfer increments i; if i reaches RES_BYTES, go to SEND_LBL, else RD_ISSUE.
- SEND_LBL: tx_data={4'b0,label}, tx_req=1 until the transfer, then FIN.
- FIN: frame_done=1 for one cycle, then IDLE.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. The index i and the load counter are 16-bit.

## Timing
- Reset values: all outputs 0 (fb_*, tx_*, core_init, label, frame_done, ovf). State goes to IDLE and the counters to 0.
- Reset mid-frame aborts immediately: no write, init or tx request is issued in the cycle after rstn is sampled low.
- Load throughput: 1 byte/cycle accepted.
- Write latency: 1 cycle from ld_valid to fb_wen.
- The last load write (fb_wen high) occurs in the same cycle as core_init, i.e. the START cycle. The core's first read is therefore issued no earlier than the cycle after the write commits.
- core_done is ignored during START and accepted from the first RUN cycle.
- Readout costs 3 cycles per byte minimum (RD_ISSUE, RD_LATCH, SEND with tx_ready=1).
- tx_data is stable while tx_req=1.
- ld_valid in START..FIN: the byte is dropped, no bank write occurs, and ovf is set. ovf clears only on reset.
- label holds from the RUN exit until the next IDLE→LOAD transition.

## Test plan
- Load 784 bytes with value = addr[7:0] at 1 byte/cycle → 784 port-A writes at addresses 0..783 with correct data. Exactly one core_init, in the cycle of the addr-783 write.
- In RUN, core writes 0xA5 at 0x0010 and reads 0x0010; core_done with label 7 → c_rdata=0xA5. Then 10 result bytes from addresses 0..9 followed by 0x07. frame_done is a single pulse and label=7.
- tx_ready low for 5 cycles on every byte → tx_req held and tx_data unchanged throughout. No byte is lost or duplicated, and 11 transfers occur in total.
- ld_valid pulse during RUN → no port-A write from the loader and ovf=1. Frame completes normally and ovf stays 1 into the next frame.
- Assert core writes during LOAD and readout → fb_wen reflects only loader writes and fb_ren only readout reads.
- rstn low for 1 cycle mid-LOAD at byte 300, then a full 784-byte load → writes restart at address 0 and core_init fires once after byte 783. RES_BYTES=0 build sends only the label byte.
